// File: rtl/segment_swap_ctl_pkg.sv
// -----------------------------------------------------------------------------
// segment_swap_ctl_pkg
//   Shared types and constants for the two-segment read scheduler.
//   - swap_state_t      : scheduler state (RUN, WAIT_WRAP, STOPPED)
//   - TRANSITION_MODE_* : encodings of the transition_mode input
//   - REP_INFINITE      : repeat value meaning "loop forever" at the default
//                         16-bit repeat width
// -----------------------------------------------------------------------------
package segment_swap_ctl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        WAIT_WRAP = 2'd1,
        STOPPED   = 2'd2
    } swap_state_t;

    localparam logic TRANSITION_MODE_BOUNDARY  = 1'b0;
    localparam logic TRANSITION_MODE_IMMEDIATE = 1'b1;

    localparam logic [15:0] REP_INFINITE = '1;

endpackage : segment_swap_ctl_pkg

// File: rtl/segment_swap_ctl.sv
// -----------------------------------------------------------------------------
// segment_swap_ctl
//   Decides which of two sample segments the sampler reads, when a requested
//   segment swap takes effect (immediately or at the end of the current
//   cycle), and when playback stops after the programmed repetitions.
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   update            : 1-cycle pulse, settings/request are valid
//   req_segment       : requested read segment
//   transition_mode   : 0 = swap at end of cycle, 1 = swap immediately
//   cycle_0 / cycle_1 : last valid sample index of segment 0 / 1
//   rep_0 / rep_1     : extra repetitions of segment 0 / 1 (all-ones = forever)
//   idx, idx_strobe   : index presented by the sampler and its consume pulse
//   segment           : active read segment
//   seg_changed       : 1-cycle pulse coincident with a segment change
//   stop              : repetitions exhausted
//   swap_pending      : boundary swap latched but not yet applied
//   swap_count        : wrapping count of segment changes
//
// Configuration
//   SEGMENT_SWAP_STATUS_EN : when defined, swap_count counts seg_changed
//                            pulses modulo 256; otherwise it is tied to 0.
// -----------------------------------------------------------------------------
module segment_swap_ctl
    import segment_swap_ctl_pkg::*;
#(
    parameter int IDX_WIDTH = 16,
    parameter int REP_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 update,
    input  logic                 req_segment,
    input  logic                 transition_mode,
    input  logic [IDX_WIDTH-1:0] cycle_0,
    input  logic [IDX_WIDTH-1:0] cycle_1,
    input  logic [REP_WIDTH-1:0] rep_0,
    input  logic [REP_WIDTH-1:0] rep_1,
    input  logic [IDX_WIDTH-1:0] idx,
    input  logic                 idx_strobe,
    output logic                 segment,
    output logic                 seg_changed,
    output logic                 stop,
    output logic                 swap_pending,
    output logic [7:0]           swap_count
);

    localparam logic [REP_WIDTH-1:0] REP_ALL_ONES = '1;
    localparam logic [REP_WIDTH-1:0] REP_ZERO     = '0;

    swap_state_t            state_q, state_d;
    logic                   segment_q, segment_d;
    logic                   seg_changed_q, seg_changed_d;
    logic                   stop_q, stop_d;
    logic                   swap_pending_q, swap_pending_d;
    logic                   target_q, target_d;
    logic [REP_WIDTH-1:0]   loop_cnt_q, loop_cnt_d;

    logic [IDX_WIDTH-1:0]   cyc_sel;
    logic [REP_WIDTH-1:0]   rep_sel;
    logic                   eoc;

    // Operands of the currently active segment and end-of-cycle detection.
    // A cycle that shrank below the current index simply never matches
    // until the timer wraps back to 0.
    always_comb begin
        cyc_sel = segment_q ? cycle_1 : cycle_0;
        rep_sel = segment_q ? rep_1   : rep_0;
        eoc     = idx_strobe && (idx == cyc_sel);
    end

    // Next-state logic; an update always takes precedence over an end-of-cycle.
    always_comb begin
        state_d        = state_q;
        segment_d      = segment_q;
        seg_changed_d  = 1'b0;
        stop_d         = stop_q;
        swap_pending_d = swap_pending_q;
        target_d       = target_q;
        loop_cnt_d     = loop_cnt_q;

        if (update) begin
            if (req_segment == segment_q) begin
                // Same segment: restart playback without a change pulse.
                state_d        = RUN;
                stop_d         = 1'b0;
                swap_pending_d = 1'b0;
                loop_cnt_d     = REP_ZERO;
            end else if ((transition_mode == TRANSITION_MODE_IMMEDIATE) ||
                         (state_q == STOPPED)) begin
                // Nothing is playing (or caller wants it now): swap at once.
                state_d        = RUN;
                segment_d      = req_segment;
                seg_changed_d  = 1'b1;
                stop_d         = 1'b0;
                swap_pending_d = 1'b0;
                loop_cnt_d     = REP_ZERO;
            end else begin
                // Boundary swap: a newer request simply overwrites the target.
                state_d        = WAIT_WRAP;
                target_d       = req_segment;
                swap_pending_d = 1'b1;
            end
        end else if (eoc) begin
            case (state_q)
                RUN: begin
                    if ((rep_sel != REP_ALL_ONES) && (loop_cnt_q == rep_sel)) begin
                        state_d = STOPPED;
                        stop_d  = 1'b1;
                    end else if (loop_cnt_q != REP_ALL_ONES) begin
                        loop_cnt_d = loop_cnt_q + REP_WIDTH'(1);
                    end else begin
                        loop_cnt_d = loop_cnt_q;
                    end
                end
                WAIT_WRAP: begin
                    // Repeat counting is suspended while a swap is pending.
                    state_d        = RUN;
                    segment_d      = target_q;
                    seg_changed_d  = 1'b1;
                    swap_pending_d = 1'b0;
                    loop_cnt_d     = REP_ZERO;
                end
                STOPPED: begin
                    state_d = STOPPED;
                end
                default: begin
                    // Unreachable encoding: recover into a clean restart.
                    state_d        = RUN;
                    stop_d         = 1'b0;
                    swap_pending_d = 1'b0;
                    loop_cnt_d     = REP_ZERO;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Scheduler state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= RUN;
            segment_q      <= 1'b0;
            seg_changed_q  <= 1'b0;
            stop_q         <= 1'b0;
            swap_pending_q <= 1'b0;
            target_q       <= 1'b0;
            loop_cnt_q     <= REP_ZERO;
        end else begin
            state_q        <= state_d;
            segment_q      <= segment_d;
            seg_changed_q  <= seg_changed_d;
            stop_q         <= stop_d;
            swap_pending_q <= swap_pending_d;
            target_q       <= target_d;
            loop_cnt_q     <= loop_cnt_d;
        end
    end

    assign segment      = segment_q;
    assign seg_changed  = seg_changed_q;
    assign stop         = stop_q;
    assign swap_pending = swap_pending_q;

`ifdef SEGMENT_SWAP_STATUS_EN
    logic [7:0] swap_count_q;

    // Swap counter advances together with each seg_changed pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swap_count_q <= 8'h00;
        end else if (seg_changed_d) begin
            swap_count_q <= swap_count_q + 8'h01;
        end else begin
            swap_count_q <= swap_count_q;
        end
    end

    assign swap_count = swap_count_q;
`else
    assign swap_count = 8'h00;
`endif

endmodule : segment_swap_ctl
